password_entry: RTL and testbench

Upstream entry stage for the access-control block. Collects four 4-bit password digits from the debounced keypad/switch path, tags them with a 2-bit user select and packs them into the 18-bit word the access controller consumes. It issues a one-cycle load pulse once the word is complete. It also enforces an inter-digit inactivity timeout and a post-load holdoff, during which new entries are ignored while the controller reads memory.

---
 rtl/password_entry_if.sv | 23 ++
 rtl/password_entry.sv | 114 +++++++++++
 tb/tb_password_entry.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/password_entry_if.sv
// Keypad-side and controller-side signals of the password entry stage.
// The master modport is the keypad/controller side; the slave modport is the entry block.
interface password_entry_if;
  logic [3:0]  _Digit_In;
  logic        _Digit_Valid;
  logic [1:0]  _User_Sel;
  logic        _Clear;
  logic [17:0] Data_Out;
  logic        Data_Load;
  logic [2:0]  Digit_Count;
  logic        Timeout;
  logic        Busy;

  modport master (
    output _Digit_In, _Digit_Valid, _User_Sel, _Clear,
    input  Data_Out, Data_Load, Digit_Count, Timeout, Busy
  );

  modport slave (
    input  _Digit_In, _Digit_Valid, _User_Sel, _Clear,
    output Data_Out, Data_Load, Digit_Count, Timeout, Busy
  );
endinterface

// File: rtl/password_entry.sv
// Collects four keypad digits plus a user select into an 18-bit word for the access
// controller, with inter-digit inactivity timeout and a post-load input holdoff.
module password_entry #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  password_entry_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, LOAD, HOLDOFF} state_t;

  state_t           state_reg;
  logic [11:0]      shift_reg;
  logic [1:0]       user_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [HO_W-1:0]  ho_cnt_reg;
  logic [2:0]       count_reg;
  logic [17:0]      data_reg;
  logic             load_reg;
  logic             timeout_reg;
  logic             busy_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      user_reg    <= '0;
      tmo_cnt_reg <= '0;
      ho_cnt_reg  <= '0;
      count_reg   <= '0;
      data_reg    <= '0;
      load_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      load_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus._Clear) begin
            shift_reg <= '0;
            count_reg <= '0;
          end else if (bus._Digit_Valid) begin
            user_reg    <= bus._User_Sel;
            shift_reg   <= {8'h00, bus._Digit_In};
            count_reg   <= 3'd1;
            tmo_cnt_reg <= '0;
            state_reg   <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus._Clear) begin
            shift_reg   <= '0;
            count_reg   <= '0;
            tmo_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else if (bus._Digit_Valid) begin
            tmo_cnt_reg <= '0;
            shift_reg   <= {shift_reg[7:0], bus._Digit_In};
            if (count_reg == 3'd3) begin
              // Outputs are registered, so the word and load pulse are set on the
              // edge entering LOAD and are therefore visible during the LOAD cycle.
              data_reg  <= {user_reg, shift_reg, bus._Digit_In};
              load_reg  <= 1'b1;
              busy_reg  <= 1'b1;
              count_reg <= 3'd4;
              state_reg <= LOAD;
            end else begin
              count_reg <= count_reg + 3'd1;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout_reg <= 1'b1;
            shift_reg   <= '0;
            count_reg   <= '0;
            tmo_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        LOAD: begin
          ho_cnt_reg <= HO_LAST;
          state_reg  <= HOLDOFF;
        end
        HOLDOFF: begin
          // Keypad input and clear are deliberately ignored until the holdoff expires.
          if (ho_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
            shift_reg <= '0;
            state_reg <= IDLE;
          end else begin
            ho_cnt_reg <= ho_cnt_reg - HO_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Data_Out    = data_reg;
  assign bus.Data_Load   = load_reg;
  assign bus.Digit_Count = count_reg;
  assign bus.Timeout     = timeout_reg;
  assign bus.Busy        = busy_reg;

endmodule

// File: tb/tb_password_entry.sv
// Directed bench for password_entry with a short timeout and holdoff.
module tb_password_entry;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int load_pulses = 0;
  int tmo_pulses = 0;

  password_entry_if bus();

  password_entry #(.TIMEOUT_CYCLES(10), .HOLDOFF_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.Data_Load) load_pulses++;
    if (bus.Timeout)   tmo_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] d);
    bus._Digit_In    = d;
    bus._Digit_Valid = 1'b1;
    tick();
    bus._Digit_Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.Data_Out !== 18'h0 || bus.Data_Load !== 1'b0 || bus.Digit_Count !== 3'd0 ||
        bus.Timeout !== 1'b0 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h load=%b cnt=%0d tmo=%b busy=%b want all zero",
               bus.Data_Out, bus.Data_Load, bus.Digit_Count, bus.Timeout, bus.Busy);
    end
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_entry_holdoff();
    int base;
    logic [3:0] d [4];
    base = load_pulses;
    d[0] = 4'h3; d[1] = 4'h7; d[2] = 4'hA; d[3] = 4'h1;
    bus._User_Sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      digit(d[i]);
      checks++;
      if (bus.Digit_Count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL entry_count got %0d want %0d", bus.Digit_Count, i + 1);
      end
    end
    digit(d[3]);
    checks++;
    if (bus.Data_Load !== 1'b1 || bus.Data_Out !== 18'h137A1 || bus.Busy !== 1'b1 ||
        bus.Digit_Count !== 3'd4) begin
      failures++;
      $display("FAIL entry_load got load=%b data=%h busy=%b cnt=%0d want 1 137a1 1 4",
               bus.Data_Load, bus.Data_Out, bus.Busy, bus.Digit_Count);
    end
    $display("load data=%h", bus.Data_Out);
    // hammer digit 5 through LOAD and all holdoff cycles
    bus._Digit_In    = 4'h5;
    bus._Digit_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        checks++;
        if (bus.Busy !== 1'b1 || bus.Data_Load !== 1'b0 || bus.Digit_Count !== 3'd4) begin
          failures++;
          $display("FAIL holdoff_lock cyc=%0d got busy=%b load=%b cnt=%0d want 1 0 4",
                   i, bus.Busy, bus.Data_Load, bus.Digit_Count);
        end
      end
    end
    bus._Digit_Valid = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Digit_Count !== 3'd0 || bus.Data_Out !== 18'h137A1 ||
        load_pulses - base != 1) begin
      failures++;
      $display("FAIL holdoff_end got busy=%b cnt=%0d data=%h loads=%0d want 0 0 137a1 1",
               bus.Busy, bus.Digit_Count, bus.Data_Out, load_pulses - base);
    end
    digit(4'h9);
    checks++;
    if (bus.Digit_Count !== 3'd1) begin
      failures++;
      $display("FAIL after_holdoff_digit got %0d want 1", bus.Digit_Count);
    end
    bus._Clear = 1'b1;
    tick();
    bus._Clear = 1'b0;
    checks++;
    if (bus.Digit_Count !== 3'd0 || bus.Data_Out !== 18'h137A1) begin
      failures++;
      $display("FAIL clear_keeps_data got cnt=%0d data=%h want 0 137a1",
               bus.Digit_Count, bus.Data_Out);
    end
    $display("holdoff lockout done");
  endtask

  task automatic test_timeout();
    int lbase;
    int tbase;
    lbase = load_pulses;
    tbase = tmo_pulses;
    digit(4'h2);
    digit(4'h4);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (bus.Timeout !== 1'b0 || bus.Digit_Count !== 3'd2) begin
        failures++;
        $display("FAIL timeout_early k=%0d got tmo=%b cnt=%0d want 0 2", k, bus.Timeout, bus.Digit_Count);
      end
    end
    tick();
    checks++;
    if (bus.Timeout !== 1'b1 || bus.Digit_Count !== 3'd0) begin
      failures++;
      $display("FAIL timeout_fire got tmo=%b cnt=%0d want 1 0", bus.Timeout, bus.Digit_Count);
    end
    tick();
    checks++;
    if (bus.Timeout !== 1'b0 || tmo_pulses - tbase != 1 || load_pulses != lbase) begin
      failures++;
      $display("FAIL timeout_single got tmo=%b pulses=%0d loads=%0d want 0 1 0",
               bus.Timeout, tmo_pulses - tbase, load_pulses - lbase);
    end
    $display("timeout pulse seen");
    digit(4'h6);
    digit(4'h7);
    for (int k = 1; k <= 8; k++) tick();
    digit(4'h8);
    checks++;
    if (bus.Digit_Count !== 3'd3 || bus.Timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_rescue got cnt=%0d tmo=%b want 3 0", bus.Digit_Count, bus.Timeout);
    end
    for (int k = 1; k <= 9; k++) tick();
    checks++;
    if (bus.Digit_Count !== 3'd3 || bus.Timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_restart got cnt=%0d tmo=%b want 3 0", bus.Digit_Count, bus.Timeout);
    end
    tick();
    checks++;
    if (bus.Timeout !== 1'b1 || bus.Digit_Count !== 3'd0) begin
      failures++;
      $display("FAIL timeout_refire got tmo=%b cnt=%0d want 1 0", bus.Timeout, bus.Digit_Count);
    end
    tick();
    $display("timeout restart done");
  endtask

  task automatic test_clear_priority();
    int tbase;
    tbase = tmo_pulses;
    bus._User_Sel = 2'b00;
    digit(4'h1);
    digit(4'h2);
    bus._Clear = 1'b1;
    digit(4'h3);
    bus._Clear = 1'b0;
    checks++;
    if (bus.Digit_Count !== 3'd0) begin
      failures++;
      $display("FAIL clear_priority got cnt=%0d want 0", bus.Digit_Count);
    end
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (tmo_pulses != tbase) begin
      failures++;
      $display("FAIL clear_no_timeout got pulses=%0d want 0", tmo_pulses - tbase);
    end
    bus._User_Sel = 2'b11;
    digit(4'h0);
    digit(4'h0);
    digit(4'h0);
    digit(4'hF);
    checks++;
    if (bus.Data_Load !== 1'b1 || bus.Data_Out !== 18'h3000F) begin
      failures++;
      $display("FAIL clear_then_entry got load=%b data=%h want 1 3000f", bus.Data_Load, bus.Data_Out);
    end
    $display("load data=%h", bus.Data_Out);
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_reset_mid();
    int lbase;
    bus._User_Sel = 2'b01;
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    lbase = load_pulses;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.Data_Out !== 18'h0 || bus.Data_Load !== 1'b0 || bus.Digit_Count !== 3'd0 ||
        bus.Busy !== 1'b0 || bus.Timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_collect got data=%h load=%b cnt=%0d busy=%b tmo=%b want zeros",
               bus.Data_Out, bus.Data_Load, bus.Digit_Count, bus.Busy, bus.Timeout);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (load_pulses != lbase || bus.Data_Out !== 18'h0) begin
      failures++;
      $display("FAIL reset_collect_noload got loads=%0d data=%h want 0 0", load_pulses - lbase, bus.Data_Out);
    end
    bus._User_Sel = 2'b10;
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    digit(4'h4);
    checks++;
    if (bus.Data_Out !== 18'h21234 || bus.Data_Load !== 1'b1) begin
      failures++;
      $display("FAIL reset_reentry got data=%h load=%b want 21234 1", bus.Data_Out, bus.Data_Load);
    end
    $display("load data=%h", bus.Data_Out);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.Data_Out !== 18'h0 || bus.Busy !== 1'b0 || bus.Digit_Count !== 3'd0 || bus.Data_Load !== 1'b0) begin
      failures++;
      $display("FAIL reset_holdoff got data=%h busy=%b cnt=%0d load=%b want 0 0 0 0",
               bus.Data_Out, bus.Busy, bus.Digit_Count, bus.Data_Load);
    end
    rst = 1'b1;
    tick();
    bus._User_Sel = 2'b00;
    digit(4'h8);
    digit(4'h9);
    digit(4'hA);
    digit(4'hB);
    checks++;
    if (bus.Data_Out !== 18'h089AB || bus.Data_Load !== 1'b1 || bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_holdoff_reentry got data=%h load=%b busy=%b want 089ab 1 1",
               bus.Data_Out, bus.Data_Load, bus.Busy);
    end
    $display("load data=%h", bus.Data_Out);
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_user_capture();
    bus._User_Sel = 2'b01;
    digit(4'hC);
    bus._User_Sel = 2'b10;
    digit(4'hD);
    bus._User_Sel = 2'b11;
    digit(4'hE);
    bus._User_Sel = 2'b00;
    digit(4'hF);
    checks++;
    if (bus.Data_Out !== 18'h1CDEF || bus.Data_Load !== 1'b1) begin
      failures++;
      $display("FAIL user_capture got data=%h load=%b want 1cdef 1", bus.Data_Out, bus.Data_Load);
    end
    $display("load data=%h", bus.Data_Out);
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Data_Out !== 18'h1CDEF) begin
      failures++;
      $display("FAIL user_capture_hold got busy=%b data=%h want 0 1cdef", bus.Busy, bus.Data_Out);
    end
  endtask

  initial begin
    bus._Digit_In    = 4'h0;
    bus._Digit_Valid = 1'b0;
    bus._User_Sel    = 2'b00;
    bus._Clear       = 1'b0;
    test_reset();
    test_entry_holdoff();
    test_timeout();
    test_clear_priority();
    test_reset_mid();
    test_user_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
